// File: rtl/crossbar_pkg.sv
// crossbar_pkg: shared types, constants and index helpers for the parametrised crossbar.
package crossbar_pkg;

    typedef enum logic {IDLE, BUSY} state_e;

    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

    function automatic int wrap_idx(input int v, input int n);
        return (v >= n) ? v - n : v;
    endfunction

endpackage

// File: rtl/crossbar_slave_port.sv
// crossbar_slave_port: one slave's candidate decode, round-robin grant FSM,
// timeout counter and slave-side muxing; drives master-side contributions.
module crossbar_slave_port
    import crossbar_pkg::*;
#(
    parameter int N_MST   = 4,
    parameter int N_SLV   = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 0,
    parameter int SLV_IDX = 0
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [N_MST-1:0]    req_i,
    input  logic [N_MST*AW-1:0] addr_i,
    input  logic [N_MST-1:0]    cmd_i,
    input  logic [N_MST*DW-1:0] wdata_i,
    input  logic                aack_i,
    input  logic [DW-1:0]       rrdata_i,
    output logic                rreq_o,
    output logic [AW-1:0]       aaddr_o,
    output logic                ccmd_o,
    output logic [DW-1:0]       wwdata_o,
    output logic [N_MST-1:0]    ack_o,
    output logic [N_MST-1:0]    err_o,
    output logic [N_MST*DW-1:0] rdata_o
);

    localparam int MW = idx_w(N_MST);
    localparam int SW = $clog2(N_SLV);
    localparam int CW = cnt_w(TIMEOUT);

    state_e         state_q, state_d;
    logic [MW-1:0]  owner_q, owner_d;
    logic [MW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [MW-1:0]  pick;
    logic [N_MST-1:0] cand;
    logic           found;
    logic           busy;
    logic           expire;

    for (genvar i = 0; i < N_MST; i++) begin : g_cand
        assign cand[i] = req_i[i] && (addr_i[i*AW+AW-1 -: SW] == SW'(SLV_IDX));
    end

    // Scanning from the far end lets the nearest candidate at or after ptr win.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = N_MST - 1; k >= 0; k--) begin
            if (cand[wrap_idx(int'(ptr_q) + k, N_MST)]) begin
                pick  = MW'(wrap_idx(int'(ptr_q) + k, N_MST));
                found = 1'b1;
            end
        end
    end

    assign busy   = (state_q == BUSY);
    assign expire = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT));

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (!busy) begin
            if (found) begin
                state_d = BUSY;
                owner_d = pick;
                ptr_d   = MW'(wrap_idx(int'(pick) + 1, N_MST));
                cnt_d   = '0;
            end
        end else if (aack_i || !req_i[owner_q] || expire) begin
            state_d = IDLE;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // A completing aack beats both abort and timeout in the same cycle.
    always_comb begin
        rreq_o   = busy && req_i[owner_q];
        aaddr_o  = busy ? addr_i[int'(owner_q)*AW +: AW] : '0;
        ccmd_o   = busy && cmd_i[owner_q];
        wwdata_o = busy ? wdata_i[int'(owner_q)*DW +: DW] : '0;
        ack_o    = '0;
        err_o    = '0;
        rdata_o  = '0;
        if (busy && (aack_i || (req_i[owner_q] && expire))) begin
            ack_o[owner_q]                    = 1'b1;
            err_o[owner_q]                    = !aack_i;
            rdata_o[int'(owner_q)*DW +: DW]   = aack_i ? rrdata_i : DW'(ERR_DATA);
        end
    end

endmodule

// File: rtl/crossbar_rr_param.sv
// crossbar_rr_param: N-master x M-slave request/ack crossbar with per-slave
// round-robin arbitration, address-decoded slave select and optional timeout.
module crossbar_rr_param
    import crossbar_pkg::*;
#(
    parameter int N_MST   = 4,
    parameter int N_SLV   = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 0
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [N_MST-1:0]    req_i,
    input  logic [N_MST*AW-1:0] addr_i,
    input  logic [N_MST-1:0]    cmd_i,
    input  logic [N_MST*DW-1:0] wdata_i,
    output logic [N_MST-1:0]    ack_o,
    output logic [N_MST*DW-1:0] rdata_o,
    output logic [N_MST-1:0]    err_o,
    output logic [N_SLV-1:0]    rreq_o,
    output logic [N_SLV*AW-1:0] aaddr_o,
    output logic [N_SLV-1:0]    ccmd_o,
    output logic [N_SLV*DW-1:0] wwdata_o,
    input  logic [N_SLV-1:0]    aack_i,
    input  logic [N_SLV*DW-1:0] rrdata_i
);

    logic [N_MST-1:0]    ack_s   [N_SLV];
    logic [N_MST-1:0]    err_s   [N_SLV];
    logic [N_MST*DW-1:0] rdata_s [N_SLV];

    for (genvar j = 0; j < N_SLV; j++) begin : g_slv
        crossbar_slave_port #(
            .N_MST  (N_MST),
            .N_SLV  (N_SLV),
            .AW     (AW),
            .DW     (DW),
            .TIMEOUT(TIMEOUT),
            .SLV_IDX(j)
        ) u_port (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .req_i   (req_i),
            .addr_i  (addr_i),
            .cmd_i   (cmd_i),
            .wdata_i (wdata_i),
            .aack_i  (aack_i[j]),
            .rrdata_i(rrdata_i[j*DW +: DW]),
            .rreq_o  (rreq_o[j]),
            .aaddr_o (aaddr_o[j*AW +: AW]),
            .ccmd_o  (ccmd_o[j]),
            .wwdata_o(wwdata_o[j*DW +: DW]),
            .ack_o   (ack_s[j]),
            .err_o   (err_s[j]),
            .rdata_o (rdata_s[j])
        );
    end

    // A master addresses one slave at a time, so the OR never merges two completions.
    always_comb begin
        ack_o   = '0;
        err_o   = '0;
        rdata_o = '0;
        for (int j = 0; j < N_SLV; j++) begin
            ack_o   = ack_o | ack_s[j];
            err_o   = err_o | err_s[j];
            rdata_o = rdata_o | rdata_s[j];
        end
    end

endmodule

// File: tb/tb_crossbar_rr_param.sv
// tb_crossbar_rr_param: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level reference model of the crossbar.
module tb_crossbar_rr_param;

    localparam int N  = 4;
    localparam int S  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   cmd = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]   ack, err;
    logic [N*DW-1:0] rdata;
    logic [S-1:0]   rreq, ccmd;
    logic [S-1:0]   aack = '0;
    logic [S*AW-1:0] aaddr;
    logic [S*DW-1:0] wwdata;
    logic [S*DW-1:0] rrdata = '0;

    crossbar_rr_param #(.N_MST(N), .N_SLV(S), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .reset_i(reset_n), .req_i(req), .addr_i(addr), .cmd_i(cmd),
        .wdata_i(wdata), .ack_o(ack), .rdata_o(rdata), .err_o(err), .rreq_o(rreq),
        .aaddr_o(aaddr), .ccmd_o(ccmd), .wwdata_o(wwdata), .aack_i(aack), .rrdata_i(rrdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;
    logic [N-1:0] last_ack = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: per slave, whether a transaction is open, who owns it,
    // the round-robin start point and how long it has waited.
    int m_busy [S] = '{default: 0};
    int m_own  [S] = '{default: 0};
    int m_ptr  [S] = '{default: 0};
    int m_cnt  [S] = '{default: 0};
    int p;
    logic [S-1:0]    e_rreq, e_ccmd;
    logic [S*AW-1:0] e_aaddr;
    logic [S*DW-1:0] e_wwdata;
    logic [N-1:0]    e_ack, e_err;
    logic [N*DW-1:0] e_rdata;

    function automatic int sel(input int i);
        return int'(addr[i*AW+AW-2 +: 2]);
    endfunction

    function automatic int rr_pick(input int j);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr[j] + k) % N;
            if (req[i] && sel(i) == j) return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        last_ack = ack;
        if (chk_en) begin
            e_rreq = '0; e_ccmd = '0; e_aaddr = '0; e_wwdata = '0;
            e_ack = '0; e_err = '0; e_rdata = '0;
            for (int j = 0; j < S; j++) begin
                if (m_busy[j] != 0) begin
                    e_rreq[j]               = req[m_own[j]];
                    e_ccmd[j]               = cmd[m_own[j]];
                    e_aaddr[j*AW +: AW]     = addr[m_own[j]*AW +: AW];
                    e_wwdata[j*DW +: DW]    = wdata[m_own[j]*DW +: DW];
                    if (aack[j]) begin
                        e_ack[m_own[j]] = 1'b1;
                        e_rdata[m_own[j]*DW +: DW] = rrdata[j*DW +: DW];
                    end else if (req[m_own[j]] && m_cnt[j] == TO) begin
                        e_ack[m_own[j]] = 1'b1;
                        e_err[m_own[j]] = 1'b1;
                        e_rdata[m_own[j]*DW +: DW] = 32'hDEADBEEF;
                    end
                end
            end
            check("m_rreq", rreq, e_rreq);
            check("m_ccmd", ccmd, e_ccmd);
            check("m_aaddr", aaddr, e_aaddr);
            check("m_wwdata", wwdata, e_wwdata);
            check("m_ack", ack, e_ack);
            check("m_err", err, e_err);
            check("m_rdata", rdata, e_rdata);
        end
        for (int j = 0; j < S; j++) begin
            if (!reset_n) begin
                m_busy[j] = 0; m_ptr[j] = 0; m_cnt[j] = 0;
            end else if (m_busy[j] != 0) begin
                if (aack[j] || !req[m_own[j]] || m_cnt[j] == TO) m_busy[j] = 0;
                else m_cnt[j]++;
            end else begin
                p = rr_pick(j);
                if (p >= 0) begin
                    m_busy[j] = 1; m_own[j] = p; m_ptr[j] = (p + 1) % N; m_cnt[j] = 0;
                end
            end
        end
    end

    int order[$];
    int gaps, done, seen, hit;
    logic [19:0] ord_v;
    logic te;
    logic [31:0] td;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_rreq", rreq, 0);
        check("reset_ack", ack, 0);
        tick;
        reset_n = 1'b1;

        // single read through slave 1
        req[1] = 1'b1; addr[63:32] = 32'h4000_0010; cmd[1] = 1'b0;
        @(negedge clk); check("rd_latency", rreq, 0);
        tick; @(negedge clk);
        check("rd_rreq", rreq, 4'b0010);
        check("rd_aaddr", aaddr[63:32], 32'h4000_0010);
        tick; aack[1] = 1'b1; rrdata[63:32] = 32'hCAFE_0001;
        @(negedge clk);
        check("rd_ack", ack, 4'b0010);
        check("rd_rdata", rdata[63:32], 32'hCAFE_0001);
        check("rd_err", err, 0);
        tick; req = '0; aack = '0;
        @(negedge clk); check("rd_idle", {rreq, ack}, 0);

        // contention on slave 2
        tick;
        for (int i = 0; i < N; i++) begin
            req[i] = 1'b1; addr[i*AW +: AW] = 32'h8000_0000 + 32'(i);
        end
        gaps = 0; done = 0; seen = 0;
        for (int c = 0; c < 60 && done < 5; c++) begin
            tick;
            if (rreq[2]) begin
                if (seen == 0) begin
                    order.push_back(int'(aaddr[64 +: 2])); seen = 1; aack[2] = 1'b0;
                end else begin
                    aack[2] = 1'b1; rrdata[95:64] = 32'h2000_0000 + 32'(done); seen = 0; done++;
                end
            end else begin
                aack[2] = 1'b0;
                if (order.size() > 0) gaps++;
            end
        end
        ord_v = '1;
        for (int k = 0; k < 5 && k < order.size(); k++) ord_v[k*4 +: 4] = 4'(order[k]);
        check("arb_order", ord_v, 20'h03210);
        check("arb_gaps", gaps, 4);
        tick; req = '0; aack = '0;

        // concurrent transactions on slaves 0 and 3
        req[0] = 1'b1; addr[31:0] = 32'h0000_0100;
        req[3] = 1'b1; addr[127:96] = 32'hC000_0200;
        @(negedge clk); check("cc_pre", rreq, 0);
        tick; @(negedge clk); check("cc_rreq", rreq, 4'b1001);
        tick; aack[0] = 1'b1; rrdata[31:0] = 32'h1111_0000;
        @(negedge clk);
        check("cc_ack0", ack, 4'b0001);
        check("cc_rdata0", rdata[31:0], 32'h1111_0000);
        check("cc_rreq3", rreq[3], 1);
        tick; aack[0] = 1'b0; req[0] = 1'b0; aack[3] = 1'b1; rrdata[127:96] = 32'h3333_0000;
        @(negedge clk);
        check("cc_ack3", ack, 4'b1000);
        check("cc_rdata3", rdata[127:96], 32'h3333_0000);
        tick; req = '0; aack = '0;

        // abort on slave 1 with M3 waiting
        req[2] = 1'b1; addr[95:64] = 32'h4000_0020;
        req[3] = 1'b1; addr[127:96] = 32'h4000_0030;
        tick; @(negedge clk);
        check("ab_rreq", rreq[1], 1);
        check("ab_grant", aaddr[63:32], 32'h4000_0020);
        tick; req[2] = 1'b0;
        @(negedge clk); check("ab_drop", {rreq[1], ack}, 0);
        tick; @(negedge clk); check("ab_idle", {rreq[1], ack}, 0);
        tick; @(negedge clk); check("ab_m3", aaddr[63:32], 32'h4000_0030);
        tick; aack[1] = 1'b1; rrdata[63:32] = 32'h5555_0000;
        @(negedge clk); check("ab_ack3", ack, 4'b1000);
        tick; req = '0; aack = '0;

        // timeout expiry with no aack
        req[0] = 1'b1; addr[31:0] = 32'h0000_0040;
        tick;
        hit = -1; te = 1'b0; td = '0;
        for (int k = 0; k <= TO + 2; k++) begin
            @(negedge clk);
            if (ack[0] && hit < 0) begin
                hit = k; te = err[0]; td = rdata[31:0];
            end
            tick;
            if (hit >= 0) req[0] = 1'b0;
        end
        req[0] = 1'b0;
        check("to_cycle", hit, TO);
        check("to_err", te, 1);
        check("to_data", td, 32'hDEADBEEF);

        // aack on the expiry cycle wins
        req[1] = 1'b1; addr[63:32] = 32'hC000_0050;
        tick;
        repeat (TO) tick;
        aack[3] = 1'b1; rrdata[127:96] = 32'hABCD_0123;
        @(negedge clk);
        check("race_ack", ack, 4'b0010);
        check("race_err", err, 0);
        check("race_rdata", rdata[63:32], 32'hABCD_0123);
        tick; req = '0; aack = '0;

        // reset while slave 0 is busy
        req[1] = 1'b1; addr[63:32] = 32'h0000_0060;
        tick; @(negedge clk); check("rst_busy", rreq[0], 1);
        tick; reset_n = 1'b0;
        tick; reset_n = 1'b1;
        req[0] = 1'b1; addr[31:0] = 32'h0000_0070;
        req[3] = 1'b1; addr[127:96] = 32'h0000_0080;
        @(negedge clk);
        check("rst_ctl", {rreq, ccmd, ack, err}, 0);
        check("rst_aaddr", aaddr, 0);
        check("rst_wwdata", wwdata, 0);
        check("rst_rdata", rdata, 0);
        tick; @(negedge clk); check("rst_ptr", aaddr[31:0], 32'h0000_0070);
        tick; aack[0] = 1'b1;
        @(negedge clk); check("rst_ack", ack, 4'b0001);
        tick; req = '0; aack = '0;
        tick;

        // randomized traffic: masters hold requests until acked
        repeat (3000) begin
            tick;
            reset_n = ($urandom_range(0, 499) != 0);
            for (int i = 0; i < N; i++) begin
                if (last_ack[i]) req[i] = 1'b0;
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    addr[i*AW +: AW] = $urandom;
                    cmd[i] = 1'($urandom);
                    wdata[i*DW +: DW] = $urandom;
                end
            end
            for (int j = 0; j < S; j++) begin
                aack[j] = ($urandom_range(0, 2) == 0);
                rrdata[j*DW +: DW] = $urandom;
            end
        end
        tick;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
